// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes, multi-cycle
// MUL occupancy of EX, HALT freeze/resume and a saturating stall-cycle counter.
module hazard_unit #(
  parameter int REG_ADDR_W = 3,
  parameter int MUL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_jump,
  input  logic                  ex_branch,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mul,
  input  logic                  ex_halt,
  input  logic                  resume,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  flush_if_id,
  output logic                  ex_hold,
  output logic                  halted,
  output logic [2:0]            hz_state,
  output logic [15:0]           stall_cycles
);

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_MUL_WAIT = 3'd1,
    ST_HALTED   = 3'd2
  } hz_state_e;

  localparam logic [3:0] MUL_INIT = 4'(MUL_CYCLES - 1);

  hz_state_e   state_r;
  hz_state_e   state_nxt_s;
  logic [3:0]  mul_cnt_r;
  logic [3:0]  mul_cnt_nxt_s;
  logic [15:0] stall_cnt_r;
  logic        lu_s;
  logic        stall_s;
  logic        bubble_s;
  logic        flush_s;
  logic        hold_s;

  // Load-use detection against the LOAD currently in EX.
  always_comb begin
    lu_s = ex_valid & ex_mem_read & ex_reg_write & id_valid &
           ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  end

  // Request decode and next-state selection.
  always_comb begin
    stall_s       = 1'b0;
    bubble_s      = 1'b0;
    flush_s       = 1'b0;
    hold_s        = 1'b0;
    state_nxt_s   = state_r;
    mul_cnt_nxt_s = mul_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (ex_valid & ex_halt) begin
          stall_s     = 1'b1;
          bubble_s    = 1'b1;
          state_nxt_s = ST_HALTED;
        end else if (ex_valid & (ex_jump | (ex_branch & ex_branch_taken))) begin
          flush_s  = 1'b1;
          bubble_s = 1'b1;
        end else if (ex_valid & ex_mul) begin
          stall_s       = 1'b1;
          hold_s        = 1'b1;
          mul_cnt_nxt_s = MUL_INIT;
          state_nxt_s   = ST_MUL_WAIT;
        end else if (lu_s) begin
          // One cycle suffices: the load moves on to MEM and forwarding covers the rest.
          stall_s  = 1'b1;
          bubble_s = 1'b1;
        end else begin
          stall_s = 1'b0;
        end
      end
      ST_MUL_WAIT: begin
        if (mul_cnt_r > 4'd1) begin
          stall_s       = 1'b1;
          hold_s        = 1'b1;
          mul_cnt_nxt_s = mul_cnt_r - 4'd1;
        end else begin
          // Final EX cycle of the MUL: release and do not re-detect it.
          mul_cnt_nxt_s = 4'd0;
          state_nxt_s   = ST_RUN;
        end
      end
      ST_HALTED: begin
        stall_s  = 1'b1;
        bubble_s = 1'b1;
        if (resume) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALTED;
        end
      end
      default: begin
        mul_cnt_nxt_s = 4'd0;
        state_nxt_s   = ST_RUN;
      end
    endcase
  end

  // Outputs are forced low while reset is held.
  always_comb begin
    stall_if     = stall_s & ~rst;
    stall_id     = stall_s & ~rst;
    bubble_ex    = bubble_s & ~rst;
    flush_if_id  = flush_s & ~rst;
    ex_hold      = hold_s & ~rst;
    halted       = (state_r == ST_HALTED) & ~rst;
    hz_state     = rst ? 3'd0 : state_r;
    stall_cycles = rst ? 16'd0 : stall_cnt_r;
  end

  // State, MUL countdown and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      mul_cnt_r   <= 4'd0;
      stall_cnt_r <= 16'd0;
    end else begin
      state_r   <= state_nxt_s;
      mul_cnt_r <= mul_cnt_nxt_s;
      if (stall_if && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end
    end
  end

  hazard_unit_checker u_checker (
    .clk         (clk),
    .rst         (rst),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .bubble_ex   (bubble_ex),
    .flush_if_id (flush_if_id),
    .ex_hold     (ex_hold),
    .halted      (halted),
    .hz_state    (hz_state)
  );

endmodule

// Structural invariants on the hazard outputs.
module hazard_unit_checker (
  input logic       clk,
  input logic       rst,
  input logic       stall_if,
  input logic       stall_id,
  input logic       bubble_ex,
  input logic       flush_if_id,
  input logic       ex_hold,
  input logic       halted,
  input logic [2:0] hz_state
);

  a_hold_no_bubble: assert property (@(posedge clk) disable iff (rst) !(ex_hold && bubble_ex));
  a_flush_no_stall: assert property (@(posedge clk) disable iff (rst) !(flush_if_id && stall_if));
  a_stall_pair:     assert property (@(posedge clk) disable iff (rst) stall_if == stall_id);
  a_halted_state:   assert property (@(posedge clk) disable iff (rst) halted == (hz_state == 3'd2));
  a_state_legal:    assert property (@(posedge clk) disable iff (rst) hz_state <= 3'd2);

endmodule
